// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI serial pins plus RAM-side word/response handshake
interface spi_slave_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 ss_n;
  logic                 mosi;
  logic                 miso;
  logic [ADDR_SIZE+1:0] rx_data;
  logic                 rx_valid;
  logic [ADDR_SIZE-1:0] tx_data;
  logic                 tx_valid;

  // Slave: the SPI front end itself
  modport slave (
    input  ss_n,
    input  mosi,
    input  tx_data,
    input  tx_valid,
    output miso,
    output rx_data,
    output rx_valid
  );

  // Master: SPI host driving the pins and the RAM answering reads
  modport master (
    output ss_n,
    output mosi,
    output tx_data,
    output tx_valid,
    input  miso,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave: MOSI frames to RAM words, RAM read data to MISO
module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  spi_slave_if.slave  bus
);

  localparam int RX_W = ADDR_SIZE + 2;
  localparam int RCW  = $clog2(RX_W + 1);
  localparam int TCW  = $clog2(ADDR_SIZE + 1);

  localparam logic [RCW-1:0] RX_LAST = RCW'(RX_W - 1);
  localparam logic [RCW-1:0] RX_FULL = RCW'(RX_W);
  localparam logic [TCW-1:0] TX_LAST = TCW'(ADDR_SIZE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [RX_W-2:0]      r_rx_shift;
  logic [RCW-1:0]       r_rx_cnt;
  logic [RX_W-1:0]      r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rd_addr_done;

  logic [ADDR_SIZE-2:0] r_tx_shift;
  logic [TCW-1:0]       r_tx_cnt;
  logic                 r_tx_active;
  logic                 r_tx_done;
  logic                 r_miso;

  logic                 w_in_frame;
  logic                 w_rx_shift;
  logic                 w_tx_load;

  assign bus.miso     = r_miso;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus shift/load enables for the datapath
  always_comb begin
    w_next_state = r_state;
    w_in_frame   = 1'b0;
    w_rx_shift   = 1'b0;
    w_tx_load    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.ss_n) w_next_state = CHK_CMD;
      end
      CHK_CMD: begin
        if (bus.ss_n)            w_next_state = IDLE;
        else if (!bus.mosi)      w_next_state = WRITE;
        else if (r_rd_addr_done) w_next_state = READ_DATA;
        else                     w_next_state = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        w_in_frame = !bus.ss_n;
        if (bus.ss_n) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    w_rx_shift = w_in_frame && (r_rx_cnt != RX_FULL);
    // Only the wait phase of a read-data frame accepts the RAM response
    w_tx_load  = w_in_frame && (r_state == READ_DATA) && (r_rx_cnt == RX_FULL)
                 && !r_tx_active && !r_tx_done && bus.tx_valid;
  end

  // Receive shifter, word strobe, read-address flag and MISO shifter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_shift     <= '0;
      r_rx_cnt       <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_done <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_cnt       <= '0;
      r_tx_active    <= 1'b0;
      r_tx_done      <= 1'b0;
      r_miso         <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == IDLE || bus.ss_n) begin
        // Outside a frame (or on abort) everything but rx_data and the flag clears
        r_rx_shift  <= '0;
        r_rx_cnt    <= '0;
        r_tx_shift  <= '0;
        r_tx_cnt    <= '0;
        r_tx_active <= 1'b0;
        r_tx_done   <= 1'b0;
        r_miso      <= 1'b0;
      end else begin
        if (w_rx_shift) begin
          r_rx_shift <= {r_rx_shift[RX_W-3:0], bus.mosi};
          r_rx_cnt   <= r_rx_cnt + RCW'(1);
          if (r_rx_cnt == RX_LAST) begin
            r_rx_data  <= {r_rx_shift, bus.mosi};
            r_rx_valid <= 1'b1;
            if (r_state == READ_ADD) r_rd_addr_done <= 1'b1;
          end
        end
        if (w_tx_load) begin
          r_miso      <= bus.tx_data[ADDR_SIZE-1];
          r_tx_shift  <= bus.tx_data[ADDR_SIZE-2:0];
          r_tx_cnt    <= TCW'(1);
          r_tx_active <= 1'b1;
        end else if (r_tx_active) begin
          if (r_tx_cnt == TX_LAST) begin
            // Last bit has had its full cycle on the line
            r_miso         <= 1'b0;
            r_tx_active    <= 1'b0;
            r_tx_done      <= 1'b1;
            r_rd_addr_done <= 1'b0;
          end else begin
            r_miso     <= r_tx_shift[ADDR_SIZE-2];
            r_tx_shift <= {r_tx_shift[ADDR_SIZE-3:0], 1'b0};
            r_tx_cnt   <= r_tx_cnt + TCW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed bench for spi_slave
module tb_spi_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  spi_slave_if #(.ADDR_SIZE(8)) bus ();

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full frame: E0, command bit, 10 data bits, optional RAM response, then ss_n high 1 cycle
  task automatic run_frame(input string tag, input logic [9:0] w, input int exp_state,
                           input bit do_resp, input logic [7:0] resp, input bit noise_tx);
    bus.ss_n     = 1'b0;
    bus.tx_valid = noise_tx;
    bus.tx_data  = 8'hFF;
    step();                                     // E0
    check_eq({tag, "_chk"}, 32'(int'(dut.r_state)), 32'd1);
    bus.mosi = w[9];
    step();                                     // E1
    check_eq({tag, "_state"}, 32'(int'(dut.r_state)), 32'(exp_state));
    for (int i = 9; i >= 0; i--) begin
      bus.mosi = w[i];
      step();                                   // E2..E11
      if (i == 1) check_eq({tag, "_rxv_early"}, 32'(bus.rx_valid), 32'd0);
    end
    check_eq({tag, "_rxv"}, 32'(bus.rx_valid), 32'd1);
    check_eq({tag, "_rxd"}, 32'(bus.rx_data), 32'(w));
    step();                                     // E12
    check_eq({tag, "_rxv_off"}, 32'(bus.rx_valid), 32'd0);
    check_eq({tag, "_miso_idle"}, 32'(bus.miso), 32'd0);
    if (do_resp) begin
      bus.tx_valid = 1'b1;
      bus.tx_data  = resp;
      step();                                   // E13
      bus.tx_valid = 1'b0;
      bus.tx_data  = ~resp;
      check_eq({tag, "_miso7"}, 32'(bus.miso), 32'(resp[7]));
      for (int j = 6; j >= 0; j--) begin
        step();
        check_eq($sformatf("%s_miso%0d", tag, j), 32'(bus.miso), 32'(resp[j]));
      end
      step();                                   // E21
      check_eq({tag, "_miso_end"}, 32'(bus.miso), 32'd0);
      check_eq({tag, "_rdflag_clr"}, 32'(dut.r_rd_addr_done), 32'd0);
    end
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.ss_n     = 1'b1;
    step();
    check_eq({tag, "_idle"}, 32'(int'(dut.r_state)), 32'd0);
    check_eq({tag, "_miso_off"}, 32'(bus.miso), 32'd0);
  endtask

  initial begin
    logic [9:0] w;
    bus.ss_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    rst          = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_eq("rst_miso", 32'(bus.miso), 32'd0);
    check_eq("rst_rxv", 32'(bus.rx_valid), 32'd0);
    check_eq("rst_rxd", 32'(bus.rx_data), 32'd0);
    check_eq("rst_state", 32'(int'(dut.r_state)), 32'd0);
    check_eq("rst_flag", 32'(dut.r_rd_addr_done), 32'd0);

    run_frame("wa", 10'h0E6, 2, 1'b0, 8'h00, 1'b0);
    check_eq("wa_flag", 32'(dut.r_rd_addr_done), 32'd0);
    run_frame("wd", 10'h1E6, 2, 1'b0, 8'h00, 1'b1);
    check_eq("wd_flag", 32'(dut.r_rd_addr_done), 32'd0);
    run_frame("ra", 10'h2E6, 3, 1'b0, 8'h00, 1'b0);
    check_eq("ra_flag", 32'(dut.r_rd_addr_done), 32'd1);
    run_frame("rd", 10'h3E6, 4, 1'b1, 8'hA5, 1'b0);

    // Abort after 5 data bits
    w = 10'h155;
    bus.ss_n = 1'b0;
    step();                                     // E0
    bus.mosi = 1'b0;
    step();                                     // E1
    for (int i = 9; i >= 5; i--) begin
      bus.mosi = w[i];
      step();
    end
    bus.ss_n = 1'b1;
    step();
    check_eq("ab_state", 32'(int'(dut.r_state)), 32'd0);
    check_eq("ab_rxv", 32'(bus.rx_valid), 32'd0);
    check_eq("ab_rxd_hold", 32'(bus.rx_data), 32'h3E6);
    run_frame("post_ab", 10'h0C3, 2, 1'b0, 8'h00, 1'b0);

    // Reset during MISO shifting of a read-data frame
    run_frame("ra2", 10'h211, 3, 1'b0, 8'h00, 1'b0);
    w = 10'h3AA;
    bus.ss_n = 1'b0;
    step();                                     // E0
    bus.mosi = 1'b1;
    step();                                     // E1
    check_eq("rr_state", 32'(int'(dut.r_state)), 32'd4);
    for (int i = 9; i >= 0; i--) begin
      bus.mosi = w[i];
      step();
    end
    step();                                     // E12
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hFF;
    step();                                     // E13
    bus.tx_valid = 1'b0;
    check_eq("rr_miso7", 32'(bus.miso), 32'd1);
    step();
    check_eq("rr_miso6", 32'(bus.miso), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rr_miso_rst", 32'(bus.miso), 32'd0);
    check_eq("rr_flag_rst", 32'(dut.r_rd_addr_done), 32'd0);
    check_eq("rr_state_rst", 32'(int'(dut.r_state)), 32'd0);
    check_eq("rr_rxd_rst", 32'(bus.rx_data), 32'd0);
    step();
    rst      = 1'b0;
    bus.ss_n = 1'b1;
    bus.mosi = 1'b0;
    step();
    run_frame("post_rst", 10'h2AB, 3, 1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
